// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode width, default bus widths and the fetch
// state encoding. Used by ir_fetch, the control unit and the datapath.
package cpu_pkg;

    localparam int unsigned OPCODE_W   = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ir_fetch.sv
// Instruction fetch unit: keeps the PC, fetches words over a req/ack
// handshake, loads the IR and holds the opcode until the CU acknowledges.
// Ports:
//   clk, rst           - clock, async active-high reset
//   mem_req/mem_addr   - fetch request and address (registered)
//   mem_rdata/mem_ack  - returned word and one-cycle completion pulse
//   data_to_cu/operand - opcode byte and operand field of the IR
//   ir_valid, cu_ack   - IR holds an unconsumed instruction / CU consumed it
//   pc_load/pc_target  - branch redirect from the datapath
//   halt               - stop fetching once the current IR is consumed
//   pc                 - address of the next fetch
module ir_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ack,
    output logic [OPCODE_W-1:0]        data_to_cu,
    output logic [DATA_W-OPCODE_W-1:0] operand,
    output logic                       ir_valid,
    input  logic                       cu_ack,
    input  logic                       pc_load,
    input  logic [ADDR_W-1:0]          pc_target,
    input  logic                       halt,
    output logic [ADDR_W-1:0]          pc
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_req_q, mem_req_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                ir_valid_q, ir_valid_d;
    logic                redirect_pend_q, redirect_pend_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [ADDR_W-1:0]   redirect_addr;

    // A redirect arriving together with the ack wins over an older saved one.
    assign redirect_addr = pc_load ? pc_target : target_q;

    // Next-state and output logic.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        mem_addr_d      = mem_addr_q;
        mem_req_d       = mem_req_q;
        ir_d            = ir_q;
        ir_valid_d      = ir_valid_q;
        redirect_pend_d = redirect_pend_q;
        target_d        = target_q;

        case (state_q)
            FETCH_IDLE: begin
                if (pc_load) begin
                    pc_d = pc_target;
                end
                if (!halt) begin
                    state_d    = FETCH_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_load ? pc_target : pc_q;
                end
            end

            FETCH_REQ: begin
                // mem_req_q=0 here is the single gap cycle after a discarded fetch.
                if (mem_req_q && mem_ack) begin
                    mem_req_d = 1'b0;
                    if (redirect_pend_q || pc_load) begin
                        pc_d            = redirect_addr;
                        mem_addr_d      = redirect_addr;
                        redirect_pend_d = 1'b0;
                    end else begin
                        ir_d       = mem_rdata;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + ADDR_W'(1);
                        state_d    = FETCH_HOLD;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    if (pc_load) begin
                        redirect_pend_d = 1'b1;
                        target_d        = pc_target;
                    end
                end
            end

            FETCH_HOLD: begin
                if (pc_load) begin
                    pc_d = pc_target;
                end
                if (cu_ack && ir_valid_q) begin
                    ir_valid_d = 1'b0;
                    if (halt) begin
                        state_d = FETCH_IDLE;
                    end else begin
                        state_d    = FETCH_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_load ? pc_target : pc_q;
                    end
                end
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FETCH_IDLE;
            pc_q            <= '0;
            mem_addr_q      <= '0;
            mem_req_q       <= 1'b0;
            ir_q            <= '0;
            ir_valid_q      <= 1'b0;
            redirect_pend_q <= 1'b0;
            target_q        <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            mem_addr_q      <= mem_addr_d;
            mem_req_q       <= mem_req_d;
            ir_q            <= ir_d;
            ir_valid_q      <= ir_valid_d;
            redirect_pend_q <= redirect_pend_d;
            target_q        <= target_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign pc         = pc_q;
    assign ir_valid   = ir_valid_q;
    assign data_to_cu = ir_q[DATA_W-1 -: OPCODE_W];
    assign operand    = ir_q[DATA_W-OPCODE_W-1:0];

endmodule

// File: tb/tb_ir_fetch.sv
// Bench for ir_fetch: directed scenarios with literal expectations followed
// by randomized stimulus, all outputs checked every cycle against a
// behavioural model of the fetch unit.
module tb_ir_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [7:0]  data_to_cu;
    logic [7:0]  operand;
    logic        ir_valid;
    logic        cu_ack;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        halt;
    logic [7:0]  pc;

    int total = 0;
    int bad   = 0;

    ir_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .data_to_cu (data_to_cu),
        .operand    (operand),
        .ir_valid   (ir_valid),
        .cu_ack     (cu_ack),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .halt       (halt),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy: a fetch is in progress; idle/holding are the other two phases.
    // m_req=0 while busy models the one dead cycle after a discarded word.
    bit        m_busy, m_holding;
    bit        m_req, m_valid, m_pend;
    bit [7:0]  m_addr, m_pc, m_saved;
    bit [15:0] m_ir;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_holding = 0; m_req = 0; m_valid = 0; m_pend = 0;
            m_addr = 0; m_pc = 0; m_saved = 0; m_ir = 0;
        end else if (m_busy) begin
            if (m_req && mem_ack) begin
                m_req = 0;
                if (m_pend || pc_load) begin
                    m_pc   = pc_load ? pc_target : m_saved;
                    m_addr = m_pc;
                    m_pend = 0;
                end else begin
                    m_ir      = mem_rdata;
                    m_valid   = 1;
                    m_pc      = 8'((int'(m_pc) + 1) % 256);
                    m_busy    = 0;
                    m_holding = 1;
                end
            end else begin
                m_req = 1;
                if (pc_load) begin
                    m_pend  = 1;
                    m_saved = pc_target;
                end
            end
        end else begin
            // idle or holding: a redirect lands in the PC immediately
            if (pc_load) m_pc = pc_target;
            if (m_holding) begin
                if (cu_ack) begin
                    m_valid   = 0;
                    m_holding = 0;
                    if (!halt) begin
                        m_busy = 1; m_req = 1; m_addr = m_pc;
                    end
                end
            end else if (!halt) begin
                m_busy = 1; m_req = 1; m_addr = m_pc;
            end
        end
    end

    // Compare every cycle on the falling edge.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_mem_req",  32'(mem_req),    32'(m_req));
            chk("m_mem_addr", 32'(mem_addr),   32'(m_addr));
            chk("m_pc",       32'(pc),         32'(m_pc));
            chk("m_ir_valid", 32'(ir_valid),   32'(m_valid));
            chk("m_opcode",   32'(data_to_cu), 32'(m_ir[15:8]));
            chk("m_operand",  32'(operand),    32'(m_ir[7:0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_ack = 0; cu_ack = 0; pc_load = 0; halt = 0;
    endtask

    initial begin
        rst = 1; mem_rdata = 0; pc_target = 0;
        idle_inputs();
        cyc();
        chk("rst_req",   32'(mem_req),  0);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_pc",    32'(pc),       0);
        chk("rst_valid", 32'(ir_valid), 0);
        chk("rst_ir",    32'({data_to_cu, operand}), 0);
        rst = 0;
        cmp_en = 1;

        // zero-wait fetch, CU acks immediately
        cyc();
        chk("zw_req0", 32'(mem_req), 1);
        chk("zw_addr0", 32'(mem_addr), 0);
        mem_ack = 1; mem_rdata = 16'hA512;
        cyc();
        chk("zw_valid", 32'(ir_valid), 1);
        chk("zw_opc", 32'(data_to_cu), 32'h0A5);
        chk("zw_opd", 32'(operand), 32'h012);
        chk("zw_pc1", 32'(pc), 1);
        mem_ack = 0; cu_ack = 1;
        cyc();
        chk("zw_addr1", 32'(mem_addr), 1);
        chk("zw_req1", 32'(mem_req), 1);
        cu_ack = 0; mem_ack = 1;
        cyc();
        mem_ack = 0; cu_ack = 1;
        cyc();
        chk("zw_addr2", 32'(mem_addr), 2);
        cu_ack = 0;

        // wait states: ack after 3 extra cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ws_req", 32'(mem_req), 1);
            chk("ws_addr", 32'(mem_addr), 2);
            chk("ws_novalid", 32'(ir_valid), 0);
        end
        mem_ack = 1; mem_rdata = 16'h1234;
        cyc();
        chk("ws_valid", 32'(ir_valid), 1);
        chk("ws_pc", 32'(pc), 3);
        mem_ack = 0;

        // redirect in HOLD together with cu_ack
        cu_ack = 1; pc_load = 1; pc_target = 8'h40;
        cyc();
        chk("rh_addr", 32'(mem_addr), 32'h40);
        chk("rh_req", 32'(mem_req), 1);
        cu_ack = 0; pc_load = 0; mem_ack = 1; mem_rdata = 16'h5566;
        cyc();
        chk("rh_pc", 32'(pc), 32'h41);
        mem_ack = 0;

        // redirect during REQ at address 5
        cu_ack = 1; pc_load = 1; pc_target = 8'h05;
        cyc();
        chk("rr_addr5", 32'(mem_addr), 5);
        cu_ack = 0; pc_target = 8'h80;
        cyc();
        chk("rr_pc5", 32'(pc), 5);
        pc_load = 0; mem_ack = 1; mem_rdata = 16'hDEAD;
        cyc();
        chk("rr_gap", 32'(mem_req), 0);
        chk("rr_discard", 32'(ir_valid), 0);
        chk("rr_pc", 32'(pc), 32'h80);
        mem_ack = 0;
        cyc();
        chk("rr_req", 32'(mem_req), 1);
        chk("rr_addr", 32'(mem_addr), 32'h80);
        mem_ack = 1; mem_rdata = 16'hBEEF;
        cyc();
        chk("rr_opc", 32'(data_to_cu), 32'h0BE);
        chk("rr_pc81", 32'(pc), 32'h81);
        mem_ack = 0;

        // PC wrap
        cu_ack = 1; pc_load = 1; pc_target = 8'hFF;
        cyc();
        cu_ack = 0; pc_load = 0; mem_ack = 1; mem_rdata = 16'h3C01;
        cyc();
        chk("wr_pc", 32'(pc), 0);
        mem_ack = 0; cu_ack = 1;
        cyc();
        chk("wr_addr", 32'(mem_addr), 0);
        cu_ack = 0; mem_ack = 1;
        cyc();
        mem_ack = 0;

        // halt at cu_ack, stray ack while idle, then resume
        halt = 1; cu_ack = 1;
        cyc();
        chk("hl_req", 32'(mem_req), 0);
        chk("hl_valid", 32'(ir_valid), 0);
        cu_ack = 0; mem_ack = 1; mem_rdata = 16'hFFFF;
        cyc();
        chk("hl_stray", 32'(data_to_cu), 32'h03C);
        mem_ack = 0;
        cyc();
        chk("hl_req2", 32'(mem_req), 0);
        halt = 0;
        cyc();
        chk("hl_resume_req", 32'(mem_req), 1);
        chk("hl_resume_addr", 32'(mem_addr), 1);

        // reset with a request outstanding
        rst = 1;
        #1;
        chk("mr_req", 32'(mem_req), 0);
        chk("mr_pc", 32'(pc), 0);
        chk("mr_addr", 32'(mem_addr), 0);
        chk("mr_ir", 32'({data_to_cu, operand}), 0);
        cyc();
        rst = 0;

        // randomized stimulus checked by the model
        for (int i = 0; i < 3000; i++) begin
            mem_ack   = ($urandom_range(0, 9) < 4);
            mem_rdata = 16'($urandom);
            cu_ack    = ($urandom_range(0, 1) == 1);
            pc_load   = ($urandom_range(0, 9) == 0);
            pc_target = 8'($urandom);
            halt      = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0;
        idle_inputs();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_fetch.md
# ir_fetch

Instruction fetch unit for the microprogrammed CPU. It keeps the program counter, fetches instruction words from program memory over a req/ack handshake, and loads the instruction register. It presents the opcode byte to the control unit's `data_from_ir` input, then holds it until the control unit acknowledges. Branch redirects from the datapath are applied through a PC-load port.

## Interface
- `ADDR_W`, default 8: program-memory address and PC width.
- `DATA_W`, default 16: instruction word width. Opcode is `[DATA_W-1 -: 8]`; operand is `[DATA_W-9:0]`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_req` out 1: fetch request, level.
- `mem_addr` out ADDR_W: fetch address; stable while `mem_req`=1.
- `mem_rdata` in DATA_W: instruction word; valid only in a cycle where `mem_ack`=1.
- `mem_ack` in 1: one-cycle completion pulse; may arrive in the first `mem_req` cycle.
- `data_to_cu` out 8: opcode byte, wired to CU `data_from_ir`.
- `operand` out DATA_W-8: operand field of the IR.
- `ir_valid` out 1: IR holds an unconsumed instruction.
- `cu_ack` in 1: CU has consumed the instruction; honoured only while `ir_valid`=1.
- `pc_load` in 1: redirect request, one cycle.
- `pc_target` in ADDR_W: redirect address, sampled with `pc_load`.
- `halt` in 1: stop fetching after the current instruction is consumed.
- `pc` out ADDR_W: current PC, the address of the next fetch.

## Operation
- **Reset values:** all outputs are 0, `pc`=0, IR=0, `redirect_pend`=0, state=IDLE. All outputs are registered.
- **IDLE**
  - If `halt`=0, go to REQ next cycle, with `mem_req`<=1 and `mem_addr`<=`pc`.
  - If `halt`=1, stay in IDLE.
- **REQ**
  - Hold `mem_req`=1 with a constant `mem_addr` until `mem_ack`=1.
  - On ack with `redirect_pend`=0:
    - IR <= `mem_rdata`, `ir_valid`<=1, `mem_req`<=0.
    - `pc` <= `pc`+1 mod 2^ADDR_W (255 wraps to 0).
    - Go to HOLD.
  - On ack with `redirect_pend`=1:
    - Discard the word and clear `redirect_pend`.
    - `pc` <= the saved target; `mem_addr` <= the saved target.
    - Stay in REQ. `mem_req` drops for exactly one cycle, then reasserts.
- **HOLD**
  - IR and `ir_valid` are held.
  - On `cu_ack`=1, `ir_valid`<=0.
    - If `halt`=1, go to IDLE.
    - Otherwise go to REQ with `mem_req`<=1 and `mem_addr`<=`pc`.
- **pc_load handling**
  - In HOLD or IDLE: `pc` <= `pc_target` at once.
    - If `cu_ack` arrives in the same cycle, the new fetch uses `pc_target`, not `pc`.
  - In REQ: save the target and set `redirect_pend`.
  - A second `pc_load` while pending overwrites the saved target (last wins).
- **Simultaneous `pc_load` and `mem_ack` in REQ:** the in-flight word is discarded and the refetch uses `pc_target`.
- **`cu_ack` while `ir_valid`=0:** ignored.
- **`mem_ack` outside REQ:** ignored, with no state change.
- **Reset mid-operation:** every register returns to its reset value at once, and any in-flight memory transaction is abandoned.

## Timing
- `mem_ack` in cycle N gives `ir_valid`=1 and new `data_to_cu` in N+1.
- `cu_ack` in cycle N gives `mem_req`=1 in N+1.
- Peak throughput is one instruction per 2 cycles, assuming zero-wait memory and a CU that acks immediately.
- A redirect landing in REQ costs the wasted fetch plus one idle request cycle.
- `pc` is updated at the ack edge, so it is visible the cycle after ack.

## Structure
- Shared package `cpu_pkg` holds:
  - `OPCODE_W`=8.
  - Default `ADDR_W` and `DATA_W`.
  - The fetch state enum: IDLE, REQ, HOLD.
- These are shared with `cu` and the datapath.
- Single module; no sub-module is needed. The PC incrementer and redirect logic stay inline.

## Test plan
- **Reset then zero-wait fetch:** rst pulse, then `mem_ack` in the first req cycle with `mem_rdata`=16'hA512 and `cu_ack` immediately.
  - `mem_addr`=0, then 1, then 2, one request every 2 cycles.
  - `data_to_cu`=8'hA5, `operand`=8'h12.
- **Wait states:** `mem_ack` delayed 3 cycles.
  - `mem_req` and `mem_addr` are held stable for 4 cycles.
  - `ir_valid` rises in the cycle after ack.
- **Redirect in HOLD:** `pc_load` with `pc_target`=8'h40, in the same cycle as `cu_ack`.
  - The next request has `mem_addr`=8'h40.
  - After that fetch completes, `pc`=8'h41.
- **Redirect during REQ:** `pc_load` with 8'h80 while waiting on ack at address 5.
  - The word from address 5 is discarded and `ir_valid` stays 0.
  - `mem_req` is low for exactly 1 cycle, then a request to 8'h80 follows.
- **PC wrap:** PC preloaded to 8'hFF and a fetch completes.
  - `pc`=8'h00 and the next `mem_addr`=8'h00.
- **Halt and reset mid-fetch:**
  - `halt`=1 at `cu_ack`: goes to IDLE and `mem_req` stays 0; releasing `halt` resumes at the current `pc`.
  - `rst` asserted with `mem_req` high: all outputs are 0 immediately.
